my_arb_16_4_way: RTL
====================

Name: my_arb_16_4_way

Overview:
- Sequential front end for the 16-bit 4-way mux datapath. It accepts four 16-bit valid/ready source channels and picks one per transfer with a round-robin arbiter.
- The grant index drives the select of an internal my_mux_16_4_way instance. The selected word is captured into a single registered output stage with a valid/ready handshake.
- Sits directly upstream of any consumer of 16-bit words. It replaces a static sel with fair, back-pressured selection.

Parameters:
- WIDTH, 16, data width per channel; fixed at 16 to match my_mux_16_4_way, and any other value is unsupported.
- RESET_PTR, 3, value of the last-grant pointer after reset; 3 gives channel 0 first priority.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  16  channel 0 data
- b  input  16  channel 1 data
- c  input  16  channel 2 data
- d  input  16  channel 3 data
- in_valid  input  4  per-channel valid; bit i is channel i
- in_ready  output  4  per-channel ready; one-hot or zero
- out  output  16  registered output data
- out_valid  output  1  out holds a word
- out_ready  input  1  consumer accepts out this cycle
- sel  output  2  channel index of the word currently in out

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - out=0, out_valid=0, sel=0, last_ptr=RESET_PTR.
  - in_ready=0 while rst_n is low.
  - An in-flight word is discarded; no partial transfer survives reset.
- load_en = !out_valid || out_ready. The output stage can accept a word this cycle.
- Arbitration (combinational):
  - Search order is last_ptr+1, last_ptr+2, last_ptr+3, last_ptr (mod 4).
  - The first index with in_valid set is the grant g.
  - No valid bits means no grant.
- in_ready[g] = load_en when a grant exists. All other in_ready bits are 0.
- in_ready must not depend combinationally on out_valid of a different cycle. It may depend on out_ready in the same cycle.
- Transfer on channel i when in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out <= word from my_mux_16_4_way with select g
  - sel <= g
  - out_valid <= 1
  - last_ptr <= g
- Drain only (out_valid && out_ready with no new transfer): out_valid <= 0. out and sel hold their old values.
- Simultaneous drain and load: the new word replaces the old in the same edge, out_valid stays 1, and throughput is 1 word/clk.
- Stall (out_valid && !out_ready):
  - in_ready=0, and out, sel, out_valid and last_ptr hold.
  - The consumer must see out stable until accepted.
- Latency: 1 clk from the accepted input edge to out_valid=1.
- last_ptr changes only on an accepted transfer. Idle cycles and stalls do not rotate priority.
- Source rule: a source holding in_valid high must keep its data stable until accepted. The block does not check this.
- Fairness: with all four valid continuously and out_ready=1, grants rotate 0,1,2,3,0,… after reset.
- Wrap-around: last_ptr=3 with channel 0 valid grants channel 0.
- Single requester: it is granted every cycle, back-to-back, with no bubble.

Optional Feature:
- Macro: MY_ARB_16_4_WAY_LOCK_EN
- Defined:
  - Adds input port in_last[3:0] and an internal lock flag plus locked index.
  - After a transfer on channel i with in_last[i]=0, lock=1 and the grant is forced to i. Other channels get in_ready=0 even if i drops in_valid.
  - The lock clears on the edge that accepts a transfer on i with in_last[i]=1.
  - last_ptr updates on every accepted transfer as normal.
  - Reset clears lock.
- Undefined: the in_last port does not exist, and every transfer is arbitrated independently.

Test Plan:
- Reset mid-stream: a=16'h1111 valid and accepted, then rst_n low for 1 clk → out=0, out_valid=0, in_ready=0 during reset; after release, channel 0 is granted first.
- All valid (a=16'hA000, b=16'hB001, c=16'hC002, d=16'hD003) with out_ready=1 for 8 clks → out sequence A000,B001,C002,D003,A000,…; sel sequence 0,1,2,3,0,…; out_valid stays 1 after the first edge.
- Back-pressure: c=16'h0C0C valid and accepted, out_ready=0 for 5 clks, d=16'h0D0D valid → out stays 0C0C, sel=2, in_ready=0; on out_ready=1, the next edge loads 0D0D with sel=3.
- Wrap and no-rotate-on-idle: channel 3 granted, 3 idle clks, then channels 0 and 3 valid → channel 0 granted.
- Single requester: only b valid with 4 different words and out_ready=1 → 4 words on consecutive clks, no bubbles, sel=1.
- LOCK_EN build: channel 2 sends 3 words with in_last=0,0,1 while channel 0 stays valid → channel 2 words are contiguous, then channel 0 is granted.

Source files
------------

// File: rtl/my_arb_16_4_way.sv
// Round-robin arbiter front end for the 16-bit 4-way mux with a registered valid/ready output stage.
// Optional packet lock (in_last port) is enabled by defining MY_ARB_16_4_WAY_LOCK_EN.

module my_mux_16_4_way (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);
  always_comb begin
    out = a;
    case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end
endmodule

module my_arb_16_4_way #(
  parameter int         WIDTH     = 16,
  parameter logic [1:0] RESET_PTR = 2'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       in_valid,
`ifdef MY_ARB_16_4_WAY_LOCK_EN
  input  logic [3:0]       in_last,
`endif
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel
);

  logic [1:0]       r_last_ptr;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [1:0]       r_sel;

  logic [1:0]       w_idx;
  logic [1:0]       w_grant;
  logic             w_grant_vld;
  logic             w_load_en;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_out;

`ifdef MY_ARB_16_4_WAY_LOCK_EN
  logic             r_lock;
  logic [1:0]       r_lock_idx;
`endif

  assign w_load_en = !r_out_valid || out_ready;

  // Scan from farthest to nearest so the nearest valid index after last_ptr wins.
  always_comb begin
    w_idx       = 2'd0;
    w_grant     = 2'd0;
    w_grant_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last_ptr + k[1:0];
      if (in_valid[w_idx]) begin
        w_grant     = w_idx;
        w_grant_vld = 1'b1;
      end
    end
`ifdef MY_ARB_16_4_WAY_LOCK_EN
    if (r_lock) begin
      w_grant     = r_lock_idx;
      w_grant_vld = in_valid[r_lock_idx];
    end
`endif
  end

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign w_xfer   = w_grant_vld && w_load_en && rst_n;
  assign in_ready = w_xfer ? (4'b0001 << w_grant) : 4'b0000;

  my_mux_16_4_way u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (w_grant),
    .out (w_mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sel       <= 2'd0;
      r_last_ptr  <= RESET_PTR;
    end else if (w_xfer) begin
      r_out       <= w_mux_out;
      r_out_valid <= 1'b1;
      r_sel       <= w_grant;
      r_last_ptr  <= w_grant;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MY_ARB_16_4_WAY_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= 2'd0;
    end else if (w_xfer) begin
      r_lock     <= !in_last[w_grant];
      r_lock_idx <= w_grant;
    end
  end
`endif

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sel       = r_sel;

endmodule
